// File: rtl/xeng_ant_buf_pkg.sv
// Shared X-engine constants and the log2 helper used to size antenna indices.
package xeng_ant_buf_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int N_BANKS        = 2;

  // Ceiling log2, evaluated at elaboration time to size index ports.
  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/xeng_ant_buf_ram.sv
// Antenna sample RAM: one write port and two synchronous read ports.
// The two read ports are built from two copies that are always written identically.
module xeng_ant_ram
  import xeng_ant_buf_pkg::*;
#(
  parameter int ADDR_BITS  = 4,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_BITS-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_BITS-1:0]  rd_addr_a,
  input  logic [ADDR_BITS-1:0]  rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  output logic [DATA_WIDTH-1:0] rd_data_b
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_WIDTH-1:0] mem_a [DEPTH];
  logic [DATA_WIDTH-1:0] mem_b [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_a[wr_addr] <= wr_data;
      mem_b[wr_addr] <= wr_data;
    end
  end

  // Output registers hold their value when no read is serviced.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else if (rd_en) begin
      rd_data_a <= mem_a[rd_addr_a];
      rd_data_b <= mem_b[rd_addr_b];
    end
  end

endmodule

// File: rtl/xeng_ant_buf.sv
// Double-buffered antenna sample store: the writer fills the free bank,
// the reader fetches baseline sample pairs from a full bank.
module xeng_ant_buf
  import xeng_ant_buf_pkg::*;
#(
  parameter int  N_ANTS     = 8,
  parameter int  DATA_WIDTH = DATA_WIDTH_DEF,
  localparam int ANT_BITS   = log2(N_ANTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  din_valid,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  wr_overflow,
  output logic [N_BANKS-1:0]    bank_full,
  input  logic                  rd_en,
  input  logic                  buf_sel,
  input  logic [ANT_BITS-1:0]   ant_a,
  input  logic [ANT_BITS-1:0]   ant_b,
  input  logic                  rd_done,
  output logic [DATA_WIDTH-1:0] dout_a,
  output logic [DATA_WIDTH-1:0] dout_b,
  output logic                  dout_valid,
  output logic                  rd_underflow
);

  logic                wr_bank;
  logic [ANT_BITS-1:0] wr_cnt;
  logic [N_BANKS-1:0]  full_d;
  logic                wr_accept;
  logic                wr_last;
  logic                rd_ok;

  assign wr_accept = din_valid && !bank_full[wr_bank];
  assign wr_last   = wr_accept && (wr_cnt == ANT_BITS'(N_ANTS - 1));
  assign rd_ok     = rd_en && bank_full[buf_sel];

  // Release first, then completion: a release aimed at the (non-full) bank
  // being completed must not cancel the new full flag.
  always_comb begin
    full_d = bank_full;
    if (rd_done) full_d[buf_sel] = 1'b0;
    if (wr_last) full_d[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank      <= 1'b0;
      wr_cnt       <= '0;
      bank_full    <= '0;
      wr_overflow  <= 1'b0;
      rd_underflow <= 1'b0;
      dout_valid   <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_cnt <= wr_cnt + ANT_BITS'(1);
        if (wr_last) wr_bank <= ~wr_bank;
      end
      bank_full    <= full_d;
      wr_overflow  <= din_valid && bank_full[wr_bank];
      rd_underflow <= rd_en && !bank_full[buf_sel];
      dout_valid   <= rd_ok;
    end
  end

  xeng_ant_ram #(
    .ADDR_BITS  (ANT_BITS + 1),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_accept),
    .wr_addr   ({wr_bank, wr_cnt}),
    .wr_data   (din),
    .rd_en     (rd_ok),
    .rd_addr_a ({buf_sel, ant_a}),
    .rd_addr_b ({buf_sel, ant_b}),
    .rd_data_a (dout_a),
    .rd_data_b (dout_b)
  );

endmodule

// File: tb/tb_xeng_ant_buf.sv
// Scoreboard bench for xeng_ant_buf: directed frames, reads, flag and pulse checks,
// and a full baseline sweep.
module tb_xeng_ant_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        din_valid;
  logic [15:0] din;
  logic        wr_overflow;
  logic [1:0]  bank_full;
  logic        rd_en;
  logic        buf_sel;
  logic [2:0]  ant_a;
  logic [2:0]  ant_b;
  logic        rd_done;
  logic [15:0] dout_a;
  logic [15:0] dout_b;
  logic        dout_valid;
  logic        rd_underflow;

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  int pushes = 0;
  int uf_cnt = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  xeng_ant_buf #(.N_ANTS(8), .DATA_WIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .din_valid    (din_valid),
    .din          (din),
    .wr_overflow  (wr_overflow),
    .bank_full    (bank_full),
    .rd_en        (rd_en),
    .buf_sel      (buf_sel),
    .ant_a        (ant_a),
    .ant_b        (ant_b),
    .rd_done      (rd_done),
    .dout_a       (dout_a),
    .dout_b       (dout_b),
    .dout_valid   (dout_valid),
    .rd_underflow (rd_underflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [15:0] d);
    din_valid = 1'b1;
    din       = d;
    step();
    din_valid = 1'b0;
  endtask

  task automatic read(input logic bs, input logic [2:0] a, input logic [2:0] b,
                      input logic done, input logic ok,
                      input logic [15:0] ea, input logic [15:0] eb);
    if (ok) begin
      exp_q.push_back({ea, eb});
      pushes++;
    end
    rd_en   = 1'b1;
    buf_sel = bs;
    ant_a   = a;
    ant_b   = b;
    rd_done = done;
    step();
    rd_en   = 1'b0;
    rd_done = 1'b0;
  endtask

  task automatic release_bank(input logic bs);
    buf_sel = bs;
    rd_done = 1'b1;
    step();
    rd_done = 1'b0;
  endtask

  // Monitor: every presented pair must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && dout_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'(dout_valid), 32'd0);
      end else begin
        pops++;
        check("dout_pair", {dout_a, dout_b}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; din_valid = 1'b0; din = '0; rd_en = 1'b0;
    buf_sel = 1'b0; ant_a = '0; ant_b = '0; rd_done = 1'b0;
    step(); step();
    check("rst_bank_full", 32'(bank_full), 32'd0);
    check("rst_dout", {dout_a, dout_b}, 32'd0);
    check("rst_pulses", {29'd0, dout_valid, wr_overflow, rd_underflow}, 32'd0);
    rst = 1'b0;

    // Frame 1 -> bank 0
    for (int k = 0; k < 8; k++) begin
      write_word(16'h1000 + 16'(k));
      check("f1_no_overflow", 32'(wr_overflow), 32'd0);
      if (k == 6) check("f1_not_full_yet", 32'(bank_full), 32'd0);
    end
    check("f1_full", 32'(bank_full), 32'b01);

    read(1'b0, 3'd2, 3'd5, 1'b0, 1'b1, 16'h1002, 16'h1005);
    read(1'b0, 3'd7, 3'd7, 1'b0, 1'b1, 16'h1007, 16'h1007);
    step();
    check("idle_valid_low", 32'(dout_valid), 32'd0);
    check("idle_data_hold", {dout_a, dout_b}, {16'h1007, 16'h1007});

    // Frame 2 -> bank 1, then an overflowing word
    for (int k = 0; k < 8; k++) write_word(16'h2000 + 16'(k));
    check("f2_both_full", 32'(bank_full), 32'b11);
    write_word(16'h3000);
    check("overflow_pulse", 32'(wr_overflow), 32'd1);
    step();
    check("overflow_one_cycle", 32'(wr_overflow), 32'd0);
    release_bank(1'b0);
    check("release_bank0", 32'(bank_full), 32'b10);

    // Resent word must land at antenna 0 of bank 0
    write_word(16'h3000);
    for (int k = 1; k < 8; k++) write_word(16'h3000 + 16'(k));
    check("f3_both_full", 32'(bank_full), 32'b11);
    read(1'b0, 3'd0, 3'd1, 1'b0, 1'b1, 16'h3000, 16'h3001);

    // Read and release bank 1 in the same cycle
    read(1'b1, 3'd0, 3'd1, 1'b1, 1'b1, 16'h2000, 16'h2001);
    check("rd_done_same_cycle", 32'(bank_full), 32'b01);
    release_bank(1'b0);
    check("release_bank0_again", 32'(bank_full), 32'b00);
    release_bank(1'b1);
    check("release_empty_noop", 32'(bank_full), 32'b00);

    // Underflow on an empty bank
    read(1'b1, 3'd3, 3'd4, 1'b0, 1'b0, 16'h0, 16'h0);
    check("underflow_pulse", 32'(rd_underflow), 32'd1);
    check("underflow_no_valid", 32'(dout_valid), 32'd0);
    check("underflow_data_hold", {dout_a, dout_b}, {16'h2000, 16'h2001});
    step();
    check("underflow_one_cycle", 32'(rd_underflow), 32'd0);

    // Reset mid-frame, with din_valid still asserted through reset
    for (int k = 0; k < 3; k++) write_word(16'h5000 + 16'(k));
    rst = 1'b1; din_valid = 1'b1; din = 16'h5555;
    step();
    rst = 1'b0; din_valid = 1'b0;
    check("midrst_bank_full", 32'(bank_full), 32'd0);
    check("midrst_dout", {dout_a, dout_b}, 32'd0);
    check("midrst_pulses", {29'd0, dout_valid, wr_overflow, rd_underflow}, 32'd0);

    for (int k = 0; k < 8; k++) write_word(16'h4000 + 16'(k));
    check("f4_bank0_full", 32'(bank_full), 32'b01);

    // Full baseline sweep in bl_order_gen order, back-to-back reads
    for (int a = 0; a < 8; a++) begin
      for (int b = a; b < 8; b++) begin
        read(1'b0, 3'(a), 3'(b), 1'b0, 1'b1, 16'h4000 + 16'(a), 16'h4000 + 16'(b));
        if (rd_underflow) uf_cnt++;
      end
    end
    step(); step();
    check("sweep_underflows", 32'(uf_cnt), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("pairs_seen", 32'(pops), 32'(pushes));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
